riscv_fetch_unit: RTL and testbench



---
 rtl/riscv_fetch_unit_pkg.sv | 14 +
 rtl/riscv_fetch_unit_if.sv | 27 ++
 rtl/riscv_fetch_unit_fifo.sv | 54 +++++
 rtl/riscv_fetch_unit.sv | 92 +++++++++
 tb/tb_riscv_fetch_unit.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_fetch_unit_pkg.sv
// Shared types and constants for the RISC-V fetch front-end.
package riscv_core_p;

  localparam int RISCV_INSTR_LEN = 32;
  localparam int RISCV_XLEN      = 32;

  localparam logic [RISCV_INSTR_LEN-1:0] NOP_INSTRUCTION = 32'h00000013;

  typedef struct packed {
    logic [RISCV_XLEN-1:0]      pc;
    logic [RISCV_INSTR_LEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/riscv_fetch_unit_if.sv
// Instruction-memory request/response channel plus the IF/ID output handshake.
interface riscv_fetch_unit_if #(
  parameter int XLEN = riscv_core_p::RISCV_XLEN
) ();
  import riscv_core_p::*;

  logic                       imem_req_valid;
  logic                       imem_req_ready;
  logic [XLEN-1:0]            imem_addr;
  logic                       imem_rsp_valid;
  logic [RISCV_INSTR_LEN-1:0] imem_rsp_data;
  logic                       if_valid;
  logic                       if_ready;
  logic [XLEN-1:0]            if_PC;
  logic [RISCV_INSTR_LEN-1:0] if_instruction;

  modport master (
    output imem_req_valid, imem_addr, if_valid, if_PC, if_instruction,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr, if_valid, if_PC, if_instruction,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready
  );

endinterface

// File: rtl/riscv_fetch_unit_fifo.sv
// Small synchronous queue of fetched {PC, instruction} entries; flush beats push and pop.
module riscv_fetch_fifo
  import riscv_core_p::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  input  fetch_entry_t  i_data,
  output fetch_entry_t  o_head,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;
  logic          w_doPush;
  logic          w_doPop;

  assign o_empty  = (r_count == '0);
  assign o_full   = (r_count == CW'(DEPTH));
  assign o_count  = r_count;
  assign o_head   = r_mem[r_rdPtr];
  assign w_doPop  = i_pop && !o_empty;
  assign w_doPush = i_push && (!o_full || w_doPop);

  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= i_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + AW'(1);
      if (w_doPop)  r_rdPtr <= r_rdPtr + AW'(1);
      r_count <= r_count + CW'(w_doPush) - CW'(w_doPop);
    end
  end

endmodule

// File: rtl/riscv_fetch_unit.sv
// Fetch front-end: credit-limited sequential requests, in-order responses, redirect flush.
module riscv_fetch_unit
  import riscv_core_p::*;
#(
  parameter int              XLEN       = RISCV_XLEN,
  parameter logic [XLEN-1:0] PC_INITIAL = 32'h00400000,
  parameter int              DEPTH      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect,
  input  logic [XLEN-1:0]    redirect_target,
  riscv_fetch_unit_if.master bus
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] r_fetchPc;
  logic [XLEN-1:0] r_rspPc;
  logic [CW-1:0]   r_pending;
  logic [CW-1:0]   r_drop;

  logic [XLEN-1:0] w_target;
  logic [CW-1:0]   w_count;
  logic [CW:0]     w_credit;
  logic            w_empty;
  logic            w_full;
  logic            w_reqValid;
  logic            w_reqFire;
  logic            w_rspLegal;
  logic            w_keep;
  logic            w_push;
  logic            w_pop;
  fetch_entry_t    w_head;
  fetch_entry_t    w_pushEntry;

  assign w_target = redirect_target & ~XLEN'(3);

  // Queued plus live in-flight fetches may never exceed the queue size,
  // so a kept response always has a free slot waiting for it.
  assign w_credit   = {1'b0, w_count} + {1'b0, r_pending} - {1'b0, r_drop};
  assign w_reqValid = !rst && !redirect && (w_credit < (CW+1)'(DEPTH));
  assign w_reqFire  = w_reqValid && bus.imem_req_ready;
  assign w_rspLegal = bus.imem_rsp_valid && (r_pending != '0);
  assign w_keep     = w_rspLegal && (r_drop == '0);
  assign w_push     = w_keep && !w_full;
  assign w_pop      = !w_empty && bus.if_ready && !redirect;

  assign w_pushEntry = '{pc: r_rspPc, instr: bus.imem_rsp_data};

  riscv_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect),
    .i_data  (w_pushEntry),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Responses issued before a redirect (including one arriving with it) are discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetchPc <= PC_INITIAL;
      r_rspPc   <= PC_INITIAL;
      r_pending <= '0;
      r_drop    <= '0;
    end else if (redirect) begin
      r_fetchPc <= w_target;
      r_rspPc   <= w_target;
      r_pending <= r_pending - CW'(w_rspLegal);
      r_drop    <= r_pending - CW'(w_rspLegal);
    end else begin
      if (w_reqFire) r_fetchPc <= r_fetchPc + XLEN'(4);
      if (w_keep)    r_rspPc   <= r_rspPc + XLEN'(4);
      r_pending <= r_pending + CW'(w_reqFire) - CW'(w_rspLegal);
      if (w_rspLegal && (r_drop != '0)) r_drop <= r_drop - CW'(1);
    end
  end

  assign bus.imem_req_valid = w_reqValid;
  assign bus.imem_addr      = r_fetchPc;
  assign bus.if_valid       = !w_empty;
  assign bus.if_PC          = w_empty ? '0 : w_head.pc;
  assign bus.if_instruction = w_empty ? NOP_INSTRUCTION : w_head.instr;

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Scoreboard bench: expected instruction stream is a +4 PC sequence restarted on reset/redirect.
`timescale 1ns/1ps
module tb_riscv_fetch_unit;
  import riscv_core_p::*;

  localparam logic [31:0] PC_INIT = 32'h00400000;
  localparam int          DEPTH   = 4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } expEntry_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } memReq_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_target;

  int          checkCount = 0;
  int          failCount  = 0;
  int          popCount   = 0;
  int          acceptCount = 0;
  int          cycle      = 0;
  int          readyPct   = 100;
  int          latMin     = 1;
  int          latMax     = 1;

  expEntry_t   expQ[$];
  logic [31:0] modelNextPc;
  memReq_t     memQ[$];

  riscv_fetch_unit_if #(.XLEN(32)) bus ();

  riscv_fetch_unit #(
    .XLEN       (32),
    .PC_INITIAL (PC_INIT),
    .DEPTH      (DEPTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .bus             (bus)
  );

  always #5 clk = ~clk;

  // Contents of instruction memory at a given byte address.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, a[31:16]};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic extendModel(input int n);
    for (int i = 0; i < n; i++) begin
      expQ.push_back('{pc: modelNextPc, instr: memWord(modelNextPc)});
      modelNextPc = modelNextPc + 32'd4;
    end
  endtask

  task automatic restartModel(input logic [31:0] start);
    expQ.delete();
    modelNextPc = {start[31:2], 2'b00};
    extendModel(32);
  endtask

  task automatic applyStimulus(input logic r, input logic rd, input logic [31:0] tgt, input logic rdy);
    @(posedge clk);
    #1;
    rst             = r;
    redirect        = rd;
    redirect_target = tgt;
    bus.if_ready    = rdy;
    if (r) restartModel(PC_INIT);
    else if (rd) restartModel(tgt);
  endtask

  // In-order memory: each accepted request answers after its latency, one response per cycle.
  initial begin
    logic        accept;
    logic [31:0] acceptAddr;
    logic        rstSeen;
    int          lat;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      accept     = bus.imem_req_valid && bus.imem_req_ready;
      acceptAddr = bus.imem_addr;
      rstSeen    = rst;
      @(posedge clk);
      cycle++;
      #1;
      if (rstSeen) begin
        memQ.delete();
        acceptCount = 0;
      end else begin
        if (bus.imem_rsp_valid && memQ.size() > 0) void'(memQ.pop_front());
        if (accept) begin
          lat = $urandom_range(latMax, latMin);
          memQ.push_back('{addr: acceptAddr, due: cycle - 1 + lat});
          acceptCount++;
        end
      end
      bus.imem_req_ready = ($urandom_range(99, 0) < readyPct);
      if (memQ.size() > 0 && memQ[0].due <= cycle) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = memWord(memQ[0].addr);
      end else begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = $urandom;
      end
    end
  end

  // Monitor: every consumed instruction must be the next one of the expected stream.
  initial begin
    expEntry_t expected;
    forever begin
      @(negedge clk);
      if (!bus.if_valid) begin
        checkOutput("idle if_instruction", bus.if_instruction, NOP_INSTRUCTION);
        checkOutput("idle if_PC", bus.if_PC, 0);
      end
      if (rst || redirect) checkOutput("req_valid in rst/redirect", bus.imem_req_valid, 0);
      if (!rst && !redirect && bus.if_valid && bus.if_ready) begin
        if (expQ.size() < 4) extendModel(32);
        expected = expQ.pop_front();
        checkOutput("stream if_PC", bus.if_PC, expected.pc);
        checkOutput("stream if_instruction", bus.if_instruction, expected.instr);
        popCount++;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          p0;
    int          inflight;
    logic        r;
    logic        rd;
    logic        rdy;
    logic [31:0] tgt;

    rst             = 1'b1;
    redirect        = 1'b0;
    redirect_target = '0;
    bus.if_ready    = 1'b0;
    restartModel(PC_INIT);

    // Reset values and first fetches with single-cycle memory
    repeat (3) applyStimulus(1, 0, 0, 1);
    @(negedge clk);
    checkOutput("reset if_valid", bus.if_valid, 0);
    checkOutput("reset req_valid", bus.imem_req_valid, 0);
    checkOutput("reset if_PC", bus.if_PC, 0);
    checkOutput("reset if_instruction", bus.if_instruction, 32'h00000013);

    applyStimulus(0, 0, 0, 1);
    @(negedge clk);
    checkOutput("first req_valid", bus.imem_req_valid, 1);
    checkOutput("first imem_addr", bus.imem_addr, PC_INIT);
    checkOutput("cycle0 if_valid", bus.if_valid, 0);
    applyStimulus(0, 0, 0, 1);
    @(negedge clk);
    checkOutput("cycle1 if_valid", bus.if_valid, 0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 0, 1);
      @(negedge clk);
      checkOutput("early if_valid", bus.if_valid, 1);
      checkOutput("early if_PC", bus.if_PC, PC_INIT + 32'(4 * k));
      checkOutput("early if_instruction", bus.if_instruction, memWord(PC_INIT + 32'(4 * k)));
    end

    // Downstream stall: credits cap queued plus outstanding fetches at DEPTH
    repeat (2) applyStimulus(1, 0, 0, 0);
    repeat (10) applyStimulus(0, 0, 0, 0);
    @(negedge clk);
    checkOutput("stall accepted requests", acceptCount, DEPTH);
    checkOutput("stall req_valid", bus.imem_req_valid, 0);
    checkOutput("stall if_valid", bus.if_valid, 1);
    checkOutput("stall head PC", bus.if_PC, PC_INIT);
    applyStimulus(0, 0, 0, 1);
    p0 = popCount;
    repeat (4) applyStimulus(0, 0, 0, 1);
    checkOutput("release pop count", popCount - p0, 4);

    // Redirect with responses in flight on a 3-cycle memory
    latMin = 3;
    latMax = 3;
    repeat (2) applyStimulus(1, 0, 0, 1);
    repeat (12) applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 1, 32'h00400102, 1);
    @(negedge clk);
    inflight = memQ.size();
    checkOutput("in-flight at redirect >= 2", (inflight >= 2), 1);
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(0, 0, 0, 1);
      @(negedge clk);
      checkOutput("post-redirect if_valid low", bus.if_valid, 0);
    end
    applyStimulus(0, 0, 0, 1);
    @(negedge clk);
    checkOutput("redirect target valid", bus.if_valid, 1);
    checkOutput("redirect target if_PC", bus.if_PC, 32'h00400100);

    // Redirect coinciding with a response and a pop; target wraps past 2^32
    latMin = 1;
    latMax = 1;
    repeat (2) applyStimulus(1, 0, 0, 1);
    repeat (6) applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 1, 32'hFFFFFFFE, 1);
    @(negedge clk);
    checkOutput("redirect cycle rsp_valid", bus.imem_rsp_valid, 1);
    checkOutput("redirect cycle if_valid", bus.if_valid, 1);
    applyStimulus(0, 0, 0, 1);
    @(negedge clk);
    checkOutput("queue empty after redirect", bus.if_valid, 0);
    applyStimulus(0, 0, 0, 1);
    @(negedge clk);
    checkOutput("still empty N+2", bus.if_valid, 0);
    applyStimulus(0, 0, 0, 1);
    @(negedge clk);
    checkOutput("wrap target valid", bus.if_valid, 1);
    checkOutput("wrap target if_PC", bus.if_PC, 32'hFFFFFFFC);
    applyStimulus(0, 0, 0, 1);
    @(negedge clk);
    checkOutput("wrapped if_PC", bus.if_PC, 32'h00000000);

    // Reset with a full queue
    repeat (8) applyStimulus(0, 0, 0, 0);
    @(negedge clk);
    checkOutput("full queue if_valid", bus.if_valid, 1);
    checkOutput("full queue req_valid", bus.imem_req_valid, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    @(negedge clk);
    checkOutput("post-reset if_valid", bus.if_valid, 0);
    checkOutput("post-reset if_instruction", bus.if_instruction, 32'h00000013);
    checkOutput("post-reset req_valid", bus.imem_req_valid, 1);
    checkOutput("post-reset imem_addr", bus.imem_addr, PC_INIT);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1);
    @(negedge clk);
    checkOutput("restart if_PC", bus.if_PC, PC_INIT);

    // Randomised traffic: ready at 50%, latency 1..4, random stalls, redirects, resets
    readyPct = 50;
    latMax   = 4;
    p0       = popCount;
    for (int n = 0; n < 2000; n++) begin
      r   = ($urandom_range(199, 0) == 0);
      rd  = !r && ($urandom_range(39, 0) == 0);
      tgt = ($urandom_range(3, 0) == 0) ? (32'hFFFFFFE0 | 32'($urandom_range(31, 0))) : $urandom;
      rdy = ($urandom_range(99, 0) < 70);
      applyStimulus(r, rd, tgt, rdy);
    end
    readyPct = 100;
    repeat (20) applyStimulus(0, 0, 0, 1);
    checkOutput("random phase progress", (popCount - p0 > 200), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
